// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin share of the single-port data_memory between the LSU (0) and debug/DMA (1).
// Latency: a request sampled at edge E0 is accessed during E0..E1; ack and read data are visible after E1.
// Backpressure: req is held until its one-cycle ack; a losing requester simply waits for a later grant.
module data_mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  // requester 0: CPU load/store unit
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  // requester 1: debug / DMA port
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  // data_memory side
  output logic                  mem_select,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_storeData,
  input  logic [DATA_WIDTH-1:0] mem_dataOut,
  output logic                  busy
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  // One captured access: direction, address and store data.
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] dat;
  } acc_t;

  logic [0:0] state;
  logic       owner;
  logic       last_served;

  logic       in_service;
  logic       elig0;
  logic       elig1;
  logic       grant_vld;
  logic       winner;
  acc_t       win_acc;

  assign in_service = (state == ACCESS);
  assign busy       = in_service;

  // Eligibility: the requester acked at this edge is exactly the owner being
  // retired, so excluding the in-service owner also blocks an immediate
  // re-serve and lets the other side take the very next slot.
  always_comb begin
    elig0     = req0 & ~(in_service & (owner == 1'b0));
    elig1     = req1 & ~(in_service & (owner == 1'b1));
    grant_vld = elig0 | elig1;
  end

  // Round-robin pick: on a tie the side that was not served last wins.
  always_comb begin
    winner = 1'b0;
    if (elig0 && elig1) begin
      winner = ~last_served;
    end else if (elig1) begin
      winner = 1'b1;
    end
    if (winner) begin
      win_acc = '{we: we1, addr: addr1, dat: wdata1};
    end else begin
      win_acc = '{we: we0, addr: addr0, dat: wdata0};
    end
  end

  // Arbitration state and registered memory drive; a grant in ACCESS chains
  // straight into another ACCESS cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_served   <= 1'b1;
      mem_select    <= 1'b0;
      mem_address   <= '0;
      mem_storeData <= '0;
    end else if (grant_vld) begin
      state         <= ACCESS;
      owner         <= winner;
      last_served   <= winner;
      mem_select    <= win_acc.we;
      mem_address   <= win_acc.addr;
      mem_storeData <= win_acc.dat;
    end else begin
      // address and store data keep their last values while idle
      state      <= IDLE;
      mem_select <= 1'b0;
    end
  end

  // Completion: pulse the owner's ack at the end of ACCESS and capture read
  // data; during ACCESS mem_select still carries the latched direction.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (in_service) begin
        if (owner) begin
          ack1 <= 1'b1;
          if (!mem_select) begin
            rdata1 <= mem_dataOut;
          end
        end else begin
          ack0 <= 1'b1;
          if (!mem_select) begin
            rdata0 <= mem_dataOut;
          end
        end
      end
    end
  end

endmodule
